// File: rtl/restoring_div_32by16.sv
// restoring_div_32by16
// Sequential 32-by-16 unsigned restoring divider. It produces one quotient bit per clock,
// so a normal operation takes 16 iteration cycles after the accepting edge. The block
// uses a start/busy/done handshake.
//
// Ports:
//   clk_i        rising-edge clock
//   reset_i      asynchronous, active-high reset
//   start_i      request; sampled only while idle
//   dividend_i   32-bit unsigned dividend, sampled on the accepting edge
//   divisor_i    16-bit unsigned divisor, sampled on the accepting edge
//   busy_o       high while iterations are in progress
//   done_o       one-cycle pulse; results valid from this cycle onward
//   quotient_o   registered 16-bit quotient (16'hFFFF on error)
//   remainder_o  registered 16-bit remainder (16'h0000 on error)
//   div_zero_o   last operation had a zero divisor
//   overflow_o   last operation's quotient did not fit in 16 bits
module restoring_div_32by16 (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [31:0] dividend_i,
    input  logic [15:0] divisor_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] quotient_o,
    output logic [15:0] remainder_o,
    output logic        div_zero_o,
    output logic        overflow_o
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic [16:0] r_q, r_d;
    logic [15:0] q_q, q_d;
    logic [15:0] d_q, d_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dz_q, dz_d;
    logic        ov_q, ov_d;
    logic [15:0] quot_q, quot_d;
    logic [15:0] rem_q, rem_d;

    logic [16:0] trial;
    logic [16:0] diff;
    logic        ge;

    // Shift the next dividend bit into the partial remainder and try the subtraction.
    // Because R < D always holds, the trial value fits in 17 bits.
    assign trial = {r_q[15:0], q_q[15]};
    assign ge    = (trial >= {1'b0, d_q});
    assign diff  = trial - {1'b0, d_q};

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        ov_d    = ov_q;
        quot_d  = quot_q;
        rem_d   = rem_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (divisor_i == 16'd0) begin
                        dz_d   = 1'b1;
                        ov_d   = 1'b0;
                        quot_d = 16'hFFFF;
                        rem_d  = 16'h0000;
                        done_d = 1'b1;
                    end else if (dividend_i[31:16] >= divisor_i) begin
                        // A quotient this large would need more than 16 bits.
                        dz_d   = 1'b0;
                        ov_d   = 1'b1;
                        quot_d = 16'hFFFF;
                        rem_d  = 16'h0000;
                        done_d = 1'b1;
                    end else begin
                        r_d     = {1'b0, dividend_i[31:16]};
                        q_d     = dividend_i[15:0];
                        d_d     = divisor_i;
                        cnt_d   = 5'd0;
                        dz_d    = 1'b0;
                        ov_d    = 1'b0;
                        busy_d  = 1'b1;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                r_d   = ge ? diff : trial;
                q_d   = {q_q[14:0], ge};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd15) begin
                    quot_d  = q_d;
                    rem_d   = r_d[15:0];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            r_q     <= 17'd0;
            q_q     <= 16'd0;
            d_q     <= 16'd0;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
            quot_q  <= 16'd0;
            rem_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign quotient_o  = quot_q;
    assign remainder_o = rem_q;
    assign div_zero_o  = dz_q;
    assign overflow_o  = ov_q;

endmodule

// File: tb/tb_restoring_div_32by16.sv
// Self-checking bench for restoring_div_32by16: directed vector table, hand-written
// multi-cycle sequences (mid-run start, asynchronous reset, back-to-back) and
// randomized operations checked against an arithmetic reference model.
module tb_restoring_div_32by16;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_zero;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    restoring_div_32by16 dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .start_i    (start),
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .busy_o     (busy),
        .done_o     (done),
        .quotient_o (quotient),
        .remainder_o(remainder),
        .div_zero_o (div_zero),
        .overflow_o (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division plus the error rules.
    function automatic void model(input logic [31:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic dz, output logic ov);
        logic [31:0] qq;
        logic [31:0] rr;
        dz = 1'b0;
        ov = 1'b0;
        q  = 16'hFFFF;
        r  = 16'h0000;
        if (b == 16'd0) begin
            dz = 1'b1;
        end else begin
            qq = a / {16'd0, b};
            rr = a % {16'd0, b};
            if (qq > 32'd65535) ov = 1'b1;
            else begin
                q = qq[15:0];
                r = rr[15:0];
            end
        end
    endfunction

    // Issue one single-cycle start and check latency, busy span, results and flags.
    task automatic run_op(input string name, input logic [31:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er,
                          input logic edz, input logic eov);
        int cyc;
        int nbusy;
        int exp_lat;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        nbusy = 0;
        while (!done && cyc < 40) begin
            if (busy) nbusy++;
            @(negedge clk);
            cyc++;
        end
        exp_lat = (edz || eov) ? 1 : 17;
        check({name, " latency"}, 32'(cyc), 32'(exp_lat));
        check({name, " busy cycles"}, 32'(nbusy), (edz || eov) ? 32'd0 : 32'd16);
        check({name, " busy at done"}, 32'(busy), 32'd0);
        check({name, " quotient"}, 32'(quotient), 32'(eq));
        check({name, " remainder"}, 32'(remainder), 32'(er));
        check({name, " div_zero"}, 32'(div_zero), 32'(edz));
        check({name, " overflow"}, 32'(overflow), 32'(eov));
        @(negedge clk);
        check({name, " done width"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [15:0] rb;
        logic [15:0] mq;
        logic [15:0] mr;
        logic        mdz;
        logic        mov;
        int          cyc;
        int          mode;
        bit          seen;

        vecs[0] = '{32'd40,         16'd8,  16'd5,     16'd0, 1'b0, 1'b0};
        vecs[1] = '{32'd7421,       16'd81, 16'd91,    16'd50, 1'b0, 1'b0};
        vecs[2] = '{32'h0000FFFF,   16'd1,  16'hFFFF,  16'd0, 1'b0, 1'b0};
        vecs[3] = '{32'd225,        16'd0,  16'hFFFF,  16'd0, 1'b1, 1'b0};
        vecs[4] = '{32'h00050000,   16'd5,  16'hFFFF,  16'd0, 1'b0, 1'b1};
        vecs[5] = '{32'h0004FFFF,   16'd5,  16'hFFFF,  16'd4, 1'b0, 1'b0};
        vecs[6] = '{32'd100,        16'd7,  16'd14,    16'd2, 1'b0, 1'b0};
        vecs[7] = '{32'hFFFEFFFF,   16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 1'b0};

        reset    = 1'b1;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 16'd0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset quotient", 32'(quotient), 32'd0);
        check("reset remainder", 32'(remainder), 32'd0);
        check("reset flags", {30'd0, div_zero, overflow}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                   vecs[i].dz, vecs[i].ov);
        end

        // Start while running is ignored and input changes mid-run have no effect.
        @(negedge clk);
        dividend = 32'd500;
        divisor  = 16'd20;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 40) begin
            if (cyc == 5) begin
                start    = 1'b1;
                dividend = 32'd1000;
                divisor  = 16'd3;
            end else if (cyc == 6) begin
                start    = 1'b0;
                dividend = 32'hDEADBEEF;
                divisor  = 16'h0000;
            end
            @(negedge clk);
            cyc++;
        end
        check("midrun latency", 32'(cyc), 32'd17);
        check("midrun quotient", 32'(quotient), 32'd25);
        check("midrun remainder", 32'(remainder), 32'd0);
        check("midrun flags", {30'd0, div_zero, overflow}, 32'd0);
        @(negedge clk);
        check("midrun no restart", 32'(busy), 32'd0);

        // Asynchronous reset mid-operation clears everything immediately.
        @(negedge clk);
        dividend = 32'd7421;
        divisor  = 16'd81;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("areset busy", 32'(busy), 32'd0);
        check("areset done", 32'(done), 32'd0);
        check("areset quotient", 32'(quotient), 32'd0);
        check("areset remainder", 32'(remainder), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("areset no done", 32'(seen), 32'd0);
        run_op("after reset", 32'd380, 16'd19, 16'd20, 16'd0, 1'b0, 1'b0);

        // Start held high: one completion every 17 cycles.
        @(negedge clk);
        dividend = 32'd540;
        divisor  = 16'd27;
        start    = 1'b1;
        for (int c = 1; c <= 55; c++) begin
            @(negedge clk);
            check($sformatf("b2b done c%0d", c), 32'(done), 32'((c % 17) == 0));
            if (done) begin
                check($sformatf("b2b quotient c%0d", c), 32'(quotient), 32'd20);
                check($sformatf("b2b remainder c%0d", c), 32'(remainder), 32'd0);
            end
        end
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("b2b drain", 32'(seen), 32'd1);

        // Randomized operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            mode = int'($urandom_range(0, 9));
            rb   = 16'($urandom);
            ra   = $urandom;
            if (mode == 0) begin
                rb = 16'd0;
            end else if (mode >= 2) begin
                if (rb == 16'd0) rb = 16'd1;
                ra = {16'($urandom_range(0, 32'(rb) - 1)), 16'($urandom)};
            end
            model(ra, rb, mq, mr, mdz, mov);
            run_op($sformatf("rand%0d", n), ra, rb, mq, mr, mdz, mov);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
